// File: rtl/irrigation_pkg.sv
// Shared definitions for the irrigation cycle scheduler and the display/alarm
// logic that decodes its state_code output.
package irrigation_pkg;

  // State codes, also presented on state_code.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DEBOUNCE = 3'd1;
  localparam logic [2:0] ST_IRRIGATE = 3'd2;
  localparam logic [2:0] ST_SOAK     = 3'd3;
  localparam logic [2:0] ST_FAULT    = 3'd4;

  // Default timing, in divisor ticks.
  localparam int DEF_DEBOUNCE_TICKS = 4;
  localparam int DEF_MIN_ON_TICKS   = 8;
  localparam int DEF_MAX_ON_TICKS   = 60;
  localparam int DEF_SOAK_TICKS     = 30;
  localparam int DEF_CNT_W          = 8;

endpackage

// File: rtl/irrigation_cycle_scheduler_if.sv
// Sensor/tick inputs and actuator/status outputs of the irrigation scheduler.
interface irrigation_cycle_scheduler_if;
  logic       tick;
  logic       conflicting_values;
  logic       earth_humidity;
  logic       low_water_level;
  logic       splinker_mode_on;
  logic       splinker_bomb;
  logic       dripper_valvule;
  logic       irrigation_active;
  logic       fault;
  logic [2:0] state_code;

  modport master (
    output tick, conflicting_values, earth_humidity, low_water_level, splinker_mode_on,
    input  splinker_bomb, dripper_valvule, irrigation_active, fault, state_code
  );

  modport slave (
    input  tick, conflicting_values, earth_humidity, low_water_level, splinker_mode_on,
    output splinker_bomb, dripper_valvule, irrigation_active, fault, state_code
  );
endinterface

// File: rtl/sensor_synchronizer.sv
// Two-flop synchroniser for a bundle of slow level inputs; clears to 0 on reset.
module sensor_synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] synced
);
  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Capture the raw levels, then re-register them to settle metastability.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= {WIDTH{1'b0}};
      sync_r <= {WIDTH{1'b0}};
    end else begin
      meta_r <= raw;
      sync_r <= meta_r;
    end
  end

  assign synced = sync_r;
endmodule

// File: rtl/irrigation_cycle_scheduler.sv
// Runs one irrigation cycle at a time: debounced start, min/max on-time,
// dry-run protection, post-cycle soak and fault recovery. Actuator outputs
// are registered decodes of the next state so they never glitch.
module irrigation_cycle_scheduler
  import irrigation_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int MIN_ON_TICKS   = DEF_MIN_ON_TICKS,
  parameter int MAX_ON_TICKS   = DEF_MAX_ON_TICKS,
  parameter int SOAK_TICKS     = DEF_SOAK_TICKS,
  parameter int CNT_W          = DEF_CNT_W
) (
  input logic                    clock,
  input logic                    reset_n,
  irrigation_cycle_scheduler_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] MIN_LIM  = CNT_W'(MIN_ON_TICKS);
  localparam logic [CNT_W-1:0] MAX_LIM  = CNT_W'(MAX_ON_TICKS);
  localparam logic [CNT_W-1:0] SOAK_LIM = CNT_W'(SOAK_TICKS);

  logic [3:0]       raw_s;
  logic [3:0]       sync_s;
  logic             conflict_s;
  logic             humid_s;
  logic             water_ok_s;
  logic             mode_sel_s;
  logic             demand_s;

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] cnt_eff_s;
  logic             mode_r;
  logic             mode_nxt_s;
  logic             bomb_r;
  logic             valve_r;
  logic             active_r;
  logic             fault_r;

  assign raw_s = {bus.conflicting_values, bus.earth_humidity,
                  bus.low_water_level, bus.splinker_mode_on};

  sensor_synchronizer #(.WIDTH(4)) u_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .raw    (raw_s),
    .synced (sync_s)
  );

  assign conflict_s = sync_s[3];
  assign humid_s    = sync_s[2];
  assign water_ok_s = sync_s[1];
  assign mode_sel_s = sync_s[0];
  assign demand_s   = !humid_s && water_ok_s && !conflict_s;

  // Tick count including the current clock's tick; never exceeds a state's limit.
  assign cnt_eff_s = bus.tick ? (cnt_r + CNT_ONE) : cnt_r;

  // Next-state logic; the counter is cleared on every state change.
  always_comb begin
    state_nxt_s = ST_IDLE;
    cnt_nxt_s   = CNT_ZERO;
    mode_nxt_s  = mode_r;
    case (state_r)
      ST_IDLE: begin
        if (conflict_s) begin
          state_nxt_s = ST_FAULT;
        end else if (demand_s) begin
          state_nxt_s = ST_DEBOUNCE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DEBOUNCE: begin
        if (conflict_s) begin
          state_nxt_s = ST_FAULT;
        end else if (!demand_s) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_eff_s == DEB_LIM) begin
          state_nxt_s = ST_IRRIGATE;
          mode_nxt_s  = mode_sel_s;
        end else begin
          state_nxt_s = ST_DEBOUNCE;
          cnt_nxt_s   = cnt_eff_s;
        end
      end
      ST_IRRIGATE: begin
        if (conflict_s) begin
          state_nxt_s = ST_FAULT;
        end else if (!water_ok_s) begin
          state_nxt_s = ST_SOAK;
        end else if (cnt_eff_s == MAX_LIM) begin
          state_nxt_s = ST_SOAK;
        end else if (humid_s && (cnt_eff_s >= MIN_LIM)) begin
          state_nxt_s = ST_SOAK;
        end else begin
          state_nxt_s = ST_IRRIGATE;
          cnt_nxt_s   = cnt_eff_s;
        end
      end
      ST_SOAK: begin
        if (conflict_s) begin
          state_nxt_s = ST_FAULT;
        end else if (cnt_eff_s == SOAK_LIM) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SOAK;
          cnt_nxt_s   = cnt_eff_s;
        end
      end
      ST_FAULT: begin
        if (conflict_s) begin
          state_nxt_s = ST_FAULT;
        end else if (cnt_eff_s == DEB_LIM) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_FAULT;
          cnt_nxt_s   = cnt_eff_s;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counter, latched mode and registered output decode.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      mode_r   <= 1'b0;
      bomb_r   <= 1'b0;
      valve_r  <= 1'b0;
      active_r <= 1'b0;
      fault_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      mode_r   <= mode_nxt_s;
      bomb_r   <= (state_nxt_s == ST_IRRIGATE) && mode_nxt_s;
      valve_r  <= (state_nxt_s == ST_IRRIGATE) && !mode_nxt_s;
      active_r <= (state_nxt_s == ST_IRRIGATE);
      fault_r  <= (state_nxt_s == ST_FAULT);
    end
  end

  assign bus.splinker_bomb     = bomb_r;
  assign bus.dripper_valvule   = valve_r;
  assign bus.irrigation_active = active_r;
  assign bus.fault             = fault_r;
  assign bus.state_code        = state_r;
endmodule

// File: tb/tb_irrigation_cycle_scheduler.sv
// Self-checking bench: directed scenarios plus random sensor activity, all
// compared against a rule-level reference model of the scheduler.
module tb_irrigation_cycle_scheduler;
  localparam int T_DEB = 4, T_MIN = 8, T_MAX = 60, T_SOAK = 30;
  localparam int S_IDLE = 0, S_DEB = 1, S_IRR = 2, S_SOAK = 3, S_FAULT = 4;

  typedef struct packed { int st; int cnt; bit mode; } mstate_t;

  logic clock = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   phase = 0;

  mstate_t m = '{S_IDLE, 0, 1'b0};
  bit [3:0] m_s1 = 4'b0000;
  bit [3:0] m_s2 = 4'b0000;

  irrigation_cycle_scheduler_if bus();

  irrigation_cycle_scheduler dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // Reference rules: what happens on one clock given synced sensors and tick.
  function automatic mstate_t model_next(input mstate_t cur, input bit [3:0] s, input bit tk);
    mstate_t nx;
    bit conf, humid, wet, sel, demand;
    int seen;
    conf = s[3]; humid = s[2]; wet = s[1]; sel = s[0];
    demand = !humid && wet && !conf;
    seen = cur.cnt + (tk ? 1 : 0);
    nx = cur;
    nx.cnt = seen;
    case (cur.st)
      S_IDLE:  begin nx.cnt = 0; if (conf) nx.st = S_FAULT; else if (demand) nx.st = S_DEB; end
      S_DEB:   begin
        if (conf) nx.st = S_FAULT;
        else if (!demand) nx.st = S_IDLE;
        else if (seen == T_DEB) begin nx.st = S_IRR; nx.mode = sel; end
      end
      S_IRR:   begin
        if (conf) nx.st = S_FAULT;
        else if (!wet) nx.st = S_SOAK;
        else if (seen == T_MAX) nx.st = S_SOAK;
        else if (humid && seen >= T_MIN) nx.st = S_SOAK;
      end
      S_SOAK:  begin if (conf) nx.st = S_FAULT; else if (seen == T_SOAK) nx.st = S_IDLE; end
      S_FAULT: begin if (conf) nx.cnt = 0; else if (seen == T_DEB) nx.st = S_IDLE; end
      default: nx.st = S_IDLE;
    endcase
    if (nx.st != cur.st) nx.cnt = 0;
    return nx;
  endfunction

  function automatic logic [6:0] model_out(input mstate_t s);
    return {(s.st == S_IRR) && s.mode, (s.st == S_IRR) && !s.mode, (s.st == S_IRR),
            (s.st == S_FAULT), 3'(s.st)};
  endfunction

  function automatic logic [6:0] obs();
    return {bus.splinker_bomb, bus.dripper_valvule, bus.irrigation_active, bus.fault, bus.state_code};
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 <= 4'b0000;
      m_s2 <= 4'b0000;
      m    <= '{S_IDLE, 0, 1'b0};
    end else begin
      m_s1 <= {bus.conflicting_values, bus.earth_humidity, bus.low_water_level, bus.splinker_mode_on};
      m_s2 <= m_s1;
      m    <= model_next(m, m_s2, bus.tick);
    end
  end

  // Advance to the next falling edge and set the tick for the coming rising edge.
  task automatic step();
    @(negedge clock);
    bus.tick = (phase == 3);
    phase = (phase + 1) % 4;
  endtask

  task automatic drive(input bit c, input bit h, input bit w, input bit s);
    bus.conflicting_values = c;
    bus.earth_humidity     = h;
    bus.low_water_level    = w;
    bus.splinker_mode_on   = s;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int n = 0; n < 16; n++) begin
      step();
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      vectors++;
      if (obs() !== 7'b0000000) begin
        miscompares++;
        $display("FAIL reset_outputs t=%0t got %b want 0000000", $time, obs());
      end
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    reset_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      step();
      vectors++;
      if (obs() !== model_out(m)) begin
        miscompares++;
        $display("FAIL reset_release t=%0t got %b want %b", $time, obs(), model_out(m));
      end
    end
  endtask

  task automatic test_sprinkler();
    int irr_ticks = 0, soak_ticks = 0;
    bit saw_irr = 1'b0, done = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 800 && !done; n++) begin
      step();
      vectors++;
      if (obs() !== model_out(m)) begin
        miscompares++;
        $display("FAIL sprinkler_model t=%0t got %b want %b", $time, obs(), model_out(m));
      end
      if (bus.state_code == 3'(S_IRR)) begin
        if (!saw_irr) begin
          saw_irr = 1'b1;
          vectors++;
          if ({bus.splinker_bomb, bus.dripper_valvule} !== 2'b10) begin
            miscompares++;
            $display("FAIL sprinkler_pump_on got %b want 10", {bus.splinker_bomb, bus.dripper_valvule});
          end
        end
        if (bus.tick) irr_ticks++;
        if (irr_ticks == 3) bus.earth_humidity = 1'b1;
      end
      if (bus.state_code == 3'(S_SOAK) && bus.tick) soak_ticks++;
      if (saw_irr && bus.state_code == 3'(S_IDLE)) done = 1'b1;
    end
    vectors++;
    if (!done) begin miscompares++; $display("FAIL sprinkler_timeout got no return to IDLE"); end
    vectors++;
    if (irr_ticks != T_MIN) begin miscompares++; $display("FAIL sprinkler_min_on got %0d ticks want %0d", irr_ticks, T_MIN); end
    vectors++;
    if (soak_ticks != T_SOAK) begin miscompares++; $display("FAIL sprinkler_soak got %0d ticks want %0d", soak_ticks, T_SOAK); end
  endtask

  task automatic test_max_cap();
    int irr_ticks = 0;
    bit saw_irr = 1'b0, done = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 1500 && !done; n++) begin
      step();
      vectors++;
      if (obs() !== model_out(m)) begin
        miscompares++;
        $display("FAIL maxcap_model t=%0t got %b want %b", $time, obs(), model_out(m));
      end
      if (bus.state_code == 3'(S_IRR)) begin
        saw_irr = 1'b1;
        vectors++;
        if ({bus.splinker_bomb, bus.dripper_valvule} !== 2'b01) begin
          miscompares++;
          $display("FAIL maxcap_mode_freeze t=%0t got %b want 01", $time, {bus.splinker_bomb, bus.dripper_valvule});
        end
        if (bus.tick) irr_ticks++;
        if (irr_ticks == 10) bus.splinker_mode_on = 1'b1;
      end
      if (bus.state_code == 3'(S_SOAK)) bus.earth_humidity = 1'b1;
      if (saw_irr && bus.state_code == 3'(S_IDLE)) done = 1'b1;
    end
    vectors++;
    if (!done) begin miscompares++; $display("FAIL maxcap_timeout got no return to IDLE"); end
    vectors++;
    if (irr_ticks != T_MAX) begin miscompares++; $display("FAIL maxcap_ticks got %0d want %0d", irr_ticks, T_MAX); end
  endtask

  task automatic test_demand_glitch();
    int deb1 = 0, deb2 = 0;
    bit glitched = 1'b0, restore = 1'b0, saw_idle = 1'b0, saw_irr = 1'b0, done = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 800 && !done; n++) begin
      step();
      vectors++;
      if (obs() !== model_out(m)) begin
        miscompares++;
        $display("FAIL glitch_model t=%0t got %b want %b", $time, obs(), model_out(m));
      end
      if (restore) begin bus.earth_humidity = 1'b0; restore = 1'b0; end
      if (bus.state_code == 3'(S_DEB) && bus.tick) begin
        if (saw_idle) deb2++; else deb1++;
      end
      if (!glitched && deb1 == 2 && bus.state_code == 3'(S_DEB)) begin
        bus.earth_humidity = 1'b1; glitched = 1'b1; restore = 1'b1;
      end
      if (glitched && !saw_irr && bus.state_code == 3'(S_IDLE)) saw_idle = 1'b1;
      if (bus.state_code == 3'(S_IRR) && !saw_irr) begin saw_irr = 1'b1; bus.earth_humidity = 1'b1; end
      if (saw_irr && bus.state_code == 3'(S_IDLE)) done = 1'b1;
    end
    vectors++;
    if (!saw_idle) begin miscompares++; $display("FAIL glitch_back_to_idle got no IDLE after glitch"); end
    vectors++;
    if (deb2 != T_DEB) begin miscompares++; $display("FAIL glitch_full_debounce got %0d ticks want %0d", deb2, T_DEB); end
    vectors++;
    if (!done) begin miscompares++; $display("FAIL glitch_timeout got no return to IDLE"); end
  endtask

  task automatic test_dry_run();
    int irr_ticks = 0;
    bit dropped = 1'b0, done = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 800 && !done; n++) begin
      step();
      vectors++;
      if (obs() !== model_out(m)) begin
        miscompares++;
        $display("FAIL dryrun_model t=%0t got %b want %b", $time, obs(), model_out(m));
      end
      if (!dropped && bus.state_code == 3'(S_IRR) && bus.tick) begin
        irr_ticks++;
        if (irr_ticks == 3) begin
          bus.low_water_level = 1'b0;
          dropped = 1'b1;
          step(); step();
          vectors++;
          if (bus.state_code !== 3'(S_IRR)) begin
            miscompares++; $display("FAIL dryrun_sync_latency got state %0d want %0d", bus.state_code, S_IRR);
          end
          step();
          vectors++;
          if ({bus.state_code, bus.dripper_valvule} !== {3'(S_SOAK), 1'b0}) begin
            miscompares++;
            $display("FAIL dryrun_to_soak got state %0d valve %b want state 3 valve 0", bus.state_code, bus.dripper_valvule);
          end
          drive(1'b0, 1'b1, 1'b1, 1'b0);
        end
      end
      if (dropped && bus.state_code == 3'(S_IDLE)) done = 1'b1;
    end
    vectors++;
    if (!done) begin miscompares++; $display("FAIL dryrun_timeout got no return to IDLE"); end
  endtask

  task automatic test_fault();
    int ph = 0, lat = 0, hold = 0, clean = 0, after = 0;
    bit done = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 1200 && !done; n++) begin
      step();
      vectors++;
      if (obs() !== model_out(m)) begin
        miscompares++;
        $display("FAIL fault_model t=%0t got %b want %b", $time, obs(), model_out(m));
      end
      case (ph)
        0: begin
          if (bus.state_code == 3'(S_IRR)) bus.earth_humidity = 1'b1;
          if (bus.state_code == 3'(S_SOAK)) begin bus.conflicting_values = 1'b1; ph = 1; end
        end
        1: begin
          lat++;
          if (bus.fault) begin
            hold++;
            if (hold == 1) begin
              vectors++;
              if (lat != 3 || bus.state_code !== 3'(S_FAULT)) begin
                miscompares++; $display("FAIL fault_entry got latency %0d state %0d want 3 and 4", lat, bus.state_code);
              end
            end
            if (hold == 6) begin bus.conflicting_values = 1'b0; bus.earth_humidity = 1'b0; ph = 2; end
          end
        end
        2: begin
          if (bus.fault && bus.tick) clean++;
          if (clean == 2) begin bus.conflicting_values = 1'b1; ph = 3; end
        end
        3: begin bus.conflicting_values = 1'b0; ph = 4; end
        default: begin
          if (bus.fault && bus.tick) after++;
          if (!bus.fault) begin
            vectors++;
            if (bus.state_code !== 3'(S_IDLE)) begin
              miscompares++; $display("FAIL fault_exit_state got %0d want %0d", bus.state_code, S_IDLE);
            end
            vectors++;
            if (after < T_DEB || after > T_DEB + 1) begin
              miscompares++; $display("FAIL fault_recovery_restart got %0d ticks want %0d..%0d", after, T_DEB, T_DEB + 1);
            end
            bus.earth_humidity = 1'b1;
            done = 1'b1;
          end
        end
      endcase
    end
    vectors++;
    if (!done) begin miscompares++; $display("FAIL fault_timeout got no recovery"); end
    for (int n = 0; n < 12; n++) begin
      step();
      vectors++;
      if (obs() !== model_out(m)) begin
        miscompares++;
        $display("FAIL fault_settle t=%0t got %b want %b", $time, obs(), model_out(m));
      end
    end
  endtask

  task automatic test_async_reset();
    bit reached = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 200 && !reached; n++) begin
      step();
      if (bus.splinker_bomb === 1'b1) reached = 1'b1;
    end
    vectors++;
    if (!reached) begin miscompares++; $display("FAIL async_reset_setup got no pump on"); end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (obs() !== 7'b0000000) begin
      miscompares++; $display("FAIL async_reset_drop t=%0t got %b want 0000000", $time, obs());
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    step(); step();
    reset_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step();
      vectors++;
      if (obs() !== model_out(m)) begin
        miscompares++; $display("FAIL async_reset_release t=%0t got %b want %b", $time, obs(), model_out(m));
      end
    end
  endtask

  task automatic test_random();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 5000; n++) begin
      step();
      vectors++;
      if (obs() !== model_out(m)) begin
        miscompares++;
        $display("FAIL random_model t=%0t got %b want %b", $time, obs(), model_out(m));
      end
      if (bus.conflicting_values) begin
        if ($urandom_range(0, 9) == 0) bus.conflicting_values = 1'b0;
      end else begin
        if ($urandom_range(0, 399) == 0) bus.conflicting_values = 1'b1;
      end
      if ($urandom_range(0, 89) == 0)  bus.earth_humidity   = !bus.earth_humidity;
      if ($urandom_range(0, 149) == 0) bus.low_water_level  = !bus.low_water_level;
      if ($urandom_range(0, 14) == 0)  bus.splinker_mode_on = !bus.splinker_mode_on;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.tick = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    test_reset();
    test_sprinkler();
    test_max_cap();
    test_demand_glitch();
    test_dry_run();
    test_fault();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
